bus_memory_responder: RTL and testbench



---
 rtl/bus_memory_responder.sv | 160 ++++++++++++++++
 tb/tb_bus_memory_responder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bus_memory_responder.sv
// bus_memory_responder: word-addressed memory model answering HRequest/HWrite
// beats from the data-cache controllers, with programmable wait states.
// Optional feature macro: MEM_RESP_BURST_EN (shorter latency for sequential
// beats within a 4-word block).
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for HRequest; captures beat on acceptance
//   S_WAIT | counting down wait states; HRequest drop aborts the beat
//   S_RESP | HReady high for one cycle; write commits at end of cycle
module bus_memory_responder #(
   parameter int DEPTH     = 1024,
   parameter int FIRST_LAT = 4,
   parameter int BEAT_LAT  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        HRequest,
   input  logic        HWrite,
   input  logic [31:0] HAddr,
   input  logic [31:0] HWData,
   input  logic [3:0]  HByteMask,
   output logic [31:0] HRData,
   output logic        HReady,
   output logic        Busy
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            wr_q, wr_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [3:0]      mask_q, mask_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [31:0]     mem [DEPTH];

   logic [AW-1:0]   req_idx;
   logic [3:0]      lat_sel;

   assign req_idx = HAddr[AW+1:2];

`ifdef MEM_RESP_BURST_EN
   logic [AW-1:0]   prev_idx_q, prev_idx_d;
   logic            prev_vld_q, prev_vld_d;
   logic            seq_hit;
   logic            unused_ok;

   // a wrap from word 3 back to word 0 gives low bits 00, which is excluded
   assign seq_hit   = prev_vld_q && (req_idx == prev_idx_q + AW'(1)) && (req_idx[1:0] != 2'b00);
   assign lat_sel   = seq_hit ? 4'(BEAT_LAT) : 4'(FIRST_LAT);
   assign unused_ok = ^{HAddr[31:AW+2], HAddr[1:0]};
`else
   logic            unused_ok;

   assign lat_sel   = 4'(FIRST_LAT);
   assign unused_ok = ^{HAddr[31:AW+2], HAddr[1:0], 4'(BEAT_LAT)};
`endif

   assign HReady = (state_q == S_RESP);
   assign Busy   = (state_q == S_WAIT) || (state_q == S_RESP);
   assign HRData = rdata_q;

   // next-state, beat capture and read-data load
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      mask_d  = mask_q;
      rdata_d = rdata_q;
`ifdef MEM_RESP_BURST_EN
      prev_idx_d = prev_idx_q;
      prev_vld_d = prev_vld_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (HRequest) begin
               wr_d    = HWrite;
               idx_d   = req_idx;
               wdata_d = HWData;
               mask_d  = HByteMask;
               if (lat_sel == 4'd1) begin
                  state_d = S_RESP;
                  if (!HWrite) rdata_d = mem[req_idx];
               end else begin
                  cnt_d   = lat_sel - 4'd2;
                  state_d = S_WAIT;
               end
            end else begin
`ifdef MEM_RESP_BURST_EN
               prev_vld_d = 1'b0;
`endif
            end
         end
         S_WAIT: begin
            if (!HRequest) begin
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = S_RESP;
               if (!wr_q) rdata_d = mem[idx_q];
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
`ifdef MEM_RESP_BURST_EN
            prev_idx_d = idx_q;
            prev_vld_d = 1'b1;
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   // control and data registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         mask_q  <= '0;
         rdata_q <= '0;
`ifdef MEM_RESP_BURST_EN
         prev_idx_q <= '0;
         prev_vld_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         mask_q  <= mask_d;
         rdata_q <= rdata_d;
`ifdef MEM_RESP_BURST_EN
         prev_idx_q <= prev_idx_d;
         prev_vld_q <= prev_vld_d;
`endif
      end
   end

   // masked write at the end of the RESP cycle; contents survive reset, but a
   // reset cycle drops the in-flight beat so nothing is written
   always_ff @(posedge clk) begin
      if (reset && (state_q == S_RESP) && wr_q) begin
         for (int b = 0; b < 4; b++) begin
            if (mask_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_bus_memory_responder.sv
// Scoreboard bench for bus_memory_responder: expected read data is queued when
// a read beat is issued and popped when HReady is observed.
module tb_bus_memory_responder;

   localparam int DEPTH     = 1024;
   localparam int FIRST_LAT = 4;
   localparam int BEAT_LAT  = 1;
`ifdef MEM_RESP_BURST_EN
   localparam int FILL_LAT  = BEAT_LAT + 1;
`else
   localparam int FILL_LAT  = FIRST_LAT + 1;
`endif

   logic        clk;
   logic        reset;
   logic        HRequest;
   logic        HWrite;
   logic [31:0] HAddr;
   logic [31:0] HWData;
   logic [3:0]  HByteMask;
   logic [31:0] HRData;
   logic        HReady;
   logic        Busy;

   int          n_checks = 0;
   int          n_err    = 0;
   logic [31:0] model [DEPTH];
   logic [31:0] exp_q [$];

   bus_memory_responder #(
      .DEPTH(DEPTH), .FIRST_LAT(FIRST_LAT), .BEAT_LAT(BEAT_LAT)
   ) dut (
      .clk(clk), .reset(reset), .HRequest(HRequest), .HWrite(HWrite),
      .HAddr(HAddr), .HWData(HWData), .HByteMask(HByteMask),
      .HRData(HRData), .HReady(HReady), .Busy(Busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Called at a negedge. Issues one beat, waits for HReady (bounded), checks
   // latency counted in negedges from issue, and the read data from the queue.
   task automatic run_beat(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] mask, input int exp_lat, input bit rel,
                           input string tag);
      logic [9:0] ix;
      int n;
      ix = addr[11:2];
      if (wr) begin
         for (int b = 0; b < 4; b++)
            if (mask[b]) model[ix][8*b +: 8] = data[8*b +: 8];
      end else begin
         exp_q.push_back(model[ix]);
      end
      HRequest  = 1'b1;
      HWrite    = wr;
      HAddr     = addr;
      HWData    = data;
      HByteMask = mask;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!HReady && n < 40);
      check($sformatf("%s_lat", tag), 32'(n), 32'(exp_lat));
      if (HReady) begin
         check($sformatf("%s_busy", tag), 32'(Busy), 32'd1);
         if (!wr) begin
            if (exp_q.size() > 0) check($sformatf("%s_rdata", tag), HRData, exp_q.pop_front());
            else check($sformatf("%s_queue", tag), 32'd0, 32'd1);
         end
      end
      if (rel) begin
         HRequest = 1'b0;
         @(negedge clk);
         check($sformatf("%s_idle_ready", tag), 32'(HReady), 32'd0);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      reset = 1'b0; HRequest = 1'b0; HWrite = 1'b0;
      HAddr = '0; HWData = '0; HByteMask = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(HReady), 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_rdata", HRData, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // 1: reset pulse mid-WAIT drops the write
      run_beat(1, 32'h40, 32'h01020304, 4'hF, FIRST_LAT, 1, "t1_prior");
      run_beat(0, 32'h40, 32'h0, 4'h0, FIRST_LAT, 1, "t1_prior_rd");
      HRequest = 1'b1; HWrite = 1'b1; HAddr = 32'h40; HWData = 32'hDEADBEEF; HByteMask = 4'hF;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      HRequest = 1'b0;
      check("t1_rst_rdata", HRData, 32'd0);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (HReady || Busy) bad++;
         @(negedge clk);
      end
      check("t1_no_ready", 32'(bad), 32'd0);
      run_beat(0, 32'h40, 32'h0, 4'h0, FIRST_LAT, 1, "t1_rd");

      // 2: basic write/read latency
      run_beat(1, 32'h100, 32'h12345678, 4'hF, FIRST_LAT, 1, "t2_wr");
      run_beat(0, 32'h100, 32'h0, 4'h0, FIRST_LAT, 1, "t2_rd");

      // 3: byte mask; HRData must hold across writes
      run_beat(1, 32'h20, 32'hAABBCCDD, 4'hF, FIRST_LAT, 1, "t3_init");
      run_beat(1, 32'h20, 32'h11223344, 4'b0101, FIRST_LAT, 1, "t3_mask");
      check("t3_rdata_hold", HRData, 32'h12345678);
      run_beat(1, 32'h20, 32'hFFFFFFFF, 4'b0000, FIRST_LAT, 1, "t3_nomask");
      run_beat(0, 32'h20, 32'h0, 4'h0, FIRST_LAT, 1, "t3_rd");
      check("t3_value", HRData, 32'hAA22CC44);

      // 4: line fill with HRequest held across beats
      for (int i = 0; i < 4; i++)
         run_beat(1, 32'h200 + 32'(4*i), 32'hA0B0C000 + 32'(i), 4'hF, FIRST_LAT, 1, "t4_pre");
      for (int i = 0; i < 4; i++)
         run_beat(0, 32'h200 + 32'(4*i), 32'h0, 4'h0, (i == 0) ? FIRST_LAT : FILL_LAT,
                  i == 3, $sformatf("t4_fill%0d", i));

      // 5: abort after two WAIT cycles
      run_beat(1, 32'h300, 32'h55667788, 4'hF, FIRST_LAT, 1, "t5_prior");
      HRequest = 1'b1; HWrite = 1'b1; HAddr = 32'h300; HWData = 32'h99999999; HByteMask = 4'hF;
      repeat (2) @(negedge clk);
      HRequest = 1'b0;
      @(negedge clk);
      check("t5_busy", 32'(Busy), 32'd0);
      check("t5_ready", 32'(HReady), 32'd0);
      @(negedge clk);
      run_beat(0, 32'h300, 32'h0, 4'h0, FIRST_LAT, 1, "t5_rd");

      // 6: address wrap
      run_beat(1, 32'h1000, 32'hCAFEF00D, 4'hF, FIRST_LAT, 1, "t6_wr");
      run_beat(0, 32'h0000, 32'h0, 4'h0, FIRST_LAT, 1, "t6_rd");
      check("t6_value", HRData, 32'hCAFEF00D);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
